// File: rtl/da_dct_rom_sequencer.sv
// Bit-serial distributed-arithmetic sequencer for one DCT coefficient.
// Captures a group of four samples, walks their bits MSB first, addresses
// the 8-entry coefficient ROM and shift-accumulates the signed ROM words.
module da_dct_rom_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROM_W  = 16,
  parameter int unsigned ACC_W  = DATA_W + ROM_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  output logic [2:0]        rom_addr,
  output logic              rom_cs,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               rom_cs_q, rom_cs_d;
  logic [2:0]         rom_addr_q, rom_addr_d;
  logic               busy_q, busy_d;

  logic [ACC_W-1:0]   rom_ext_c;
  logic [ACC_W-1:0]   term_c;
  logic [ACC_W-1:0]   acc_next_c;

  // ROM address for one bit slice: sample 0 selects the mirrored half.
  function automatic logic [2:0] addr_f(input logic b0, input logic b1,
                                        input logic b2, input logic b3);
    return b0 ? ~{b1, b2, b3} : {b1, b2, b3};
  endfunction

  // Signed ROM term and the shift-and-add step; the sign-bit slice subtracts.
  always_comb begin
    rom_ext_c  = ACC_W'($signed(rom_data));
    term_c     = s0_q[DATA_W-1] ? (-rom_ext_c) : rom_ext_c;
    if (cnt_q == CNT_W'(DATA_W - 1)) begin
      acc_next_c = (acc_q << 1) - term_c;
    end else begin
      acc_next_c = (acc_q << 1) + term_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          s0_d       = x0;
          s1_d       = x1;
          s2_d       = x2;
          s3_d       = x3;
          acc_d      = '0;
          cnt_d      = CNT_W'(DATA_W - 1);
          rom_cs_d   = 1'b1;
          rom_addr_d = addr_f(x0[DATA_W-1], x1[DATA_W-1], x2[DATA_W-1], x3[DATA_W-1]);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        acc_d      = acc_next_c;
        s0_d       = {s0_q[DATA_W-2:0], 1'b0};
        s1_d       = {s1_q[DATA_W-2:0], 1'b0};
        s2_d       = {s2_q[DATA_W-2:0], 1'b0};
        s3_d       = {s3_q[DATA_W-2:0], 1'b0};
        // Address is prefetched one slice ahead so the registered port lines up.
        rom_addr_d = addr_f(s0_q[DATA_W-2], s1_q[DATA_W-2], s2_q[DATA_W-2], s3_q[DATA_W-2]);
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d       = '0;
          out_data_d  = acc_next_c;
          out_valid_d = 1'b1;
          rom_cs_d    = 1'b0;
          rom_addr_d  = 3'd0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        rom_cs_d    = 1'b0;
        rom_addr_d  = 3'd0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rom_cs    = rom_cs_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_da_dct_rom_sequencer.sv
// Randomized bench for the DA DCT ROM sequencer with a sum-of-products model.
module tb_da_dct_rom_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x0, x1, x2, x3;
  logic [2:0]  rom_addr;
  logic        rom_cs;
  logic [15:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic        busy;

  logic [15:0] rom_tbl [8];
  int          vectors;
  int          miscompares;
  int          cyc;
  int          last_hs;
  bit          b2b_ok;

  da_dct_rom_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ROM; outputs a poison word when deselected.
  always_comb rom_data = rom_cs ? rom_tbl[rom_addr] : 16'hDEAD;

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected ROM index for bit slice j (mirror across the table when x0 bit is set).
  function automatic logic [2:0] model_addr(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d,
                                            input int j);
    logic [2:0] idx;
    idx = {b[j], c[j], d[j]};
    if (a[j]) idx = 3'd7 - idx;
    return idx;
  endfunction

  // Coefficient as a weighted sum over bit slices, two's complement weights.
  function automatic longint model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d);
    longint sum, r, w;
    sum = 0;
    for (int j = 0; j < 16; j++) begin
      r = longint'($signed(rom_tbl[model_addr(a, b, c, d, j)]));
      if (a[j]) r = -r;
      w = (j == 15) ? -(longint'(1) <<< 15) : (longint'(1) <<< j);
      sum += w * r;
    end
    return sum;
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rom_cs", rom_cs, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rom_addr", rom_addr, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b2b_ok = 1'b0;
  endtask

  // One group; hold = DONE cycles with out_ready low, abort_at = RUN slice or 100 for DONE.
  task automatic run_group(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input int hold, input int abort_at);
    longint exp_v;
    int     t;
    int     hs;
    exp_v = model(a, b, c, d);
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    x0 = a; x1 = b; x2 = c; x3 = d;
    @(posedge clk);
    #1 hs = cyc;
    if (b2b_ok) check("period", hs - last_hs, 18);
    last_hs = hs;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'($urandom);
      x0 = 16'($urandom); x1 = 16'($urandom); x2 = 16'($urandom); x3 = 16'($urandom);
      check("rom_cs_run", rom_cs, 1);
      check("rom_addr", rom_addr, model_addr(a, b, c, d, 15 - k));
      check("out_valid_run", out_valid, 0);
      check("in_ready_run", in_ready, 0);
      if (abort_at == k) begin
        do_reset();
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("out_valid_rise", out_valid, 1);
    check("rom_cs_done", rom_cs, 0);
    check("rom_addr_done", rom_addr, 0);
    check("busy_done", busy, 1);
    check("out_data", $signed(out_data), exp_v);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      x0 = 16'($urandom);
      if (abort_at == 100 && h == hold / 2) begin
        do_reset();
        return;
      end
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_data", $signed(out_data), exp_v);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (hold > 0) @(negedge clk);
    else @(negedge clk);
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_data", $signed(out_data), exp_v);
    b2b_ok = (hold == 0);
  endtask

  task automatic rand_rom();
    for (int i = 0; i < 8; i++) begin
      rom_tbl[i] = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; last_hs = 0; b2b_ok = 1'b0;
    for (int i = 0; i < 8; i++) rom_tbl[i] = 16'($urandom);
    rom_tbl[0] = 16'hA57D;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      x0 = 16'($urandom); x1 = 16'($urandom); x2 = 16'($urandom); x3 = 16'($urandom);
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_rom_cs", rom_cs, 0);
      check("reset_out_data", out_data, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed slices with ROM[0] = 0xA57D.
    run_group(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, -1);
    check("zero_inputs_value", $signed(out_data), 23171);
    run_group(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, -1);
    check("ones_inputs_value", $signed(out_data), -23171);
    run_group(16'h0000, 16'h0001, 16'h0001, 16'h0001, 0, -1);

    // Backpressure then an immediate follow-on group.
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 10, -1);
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);

    // Abort in RUN slice 7, then in DONE; each followed by a clean group.
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 7);
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 6, 100);
    run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, -1);

    // Random ROM contents, samples and backpressure.
    for (int n = 0; n < 24; n++) begin
      rand_rom();
      run_group(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
